// File: rtl/match_req_dispatch_pkg.sv
// Shared types and constants for the match request dispatcher.
// Sizes the lane mask, lane tag, channel mask and the dispatcher FSM.
package match_req_dispatch_pkg;

   localparam int unsigned LAZY_LEN         = 4;
   localparam int unsigned LAZY_LEN_LOG2    = 2;
   localparam int unsigned NUM_MATCH_REQ_CH = 2;
   localparam int unsigned TAG_BITS         = LAZY_LEN_LOG2;
   localparam int unsigned ADDR_BITS        = 32;

   typedef logic [LAZY_LEN-1:0]         lane_mask_t;
   typedef logic [NUM_MATCH_REQ_CH-1:0] ch_mask_t;
   typedef logic [TAG_BITS-1:0]         tag_t;
   typedef logic [ADDR_BITS-1:0]        addr_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ANNOUNCE,
      ST_ISSUE,
      ST_WAIT
   } state_t;

   typedef struct packed {
      tag_t  tag;
      addr_t addr;
   } req_payload_t;

   // Index of the lowest set lane; zero for an empty mask.
   function automatic tag_t lowest_lane(input lane_mask_t mask);
      tag_t lane;
      lane = '0;
      for (int i = LAZY_LEN - 1; i >= 0; i--) begin
         if (mask[i]) lane = TAG_BITS'(i);
      end
      return lane;
   endfunction

endpackage

// File: rtl/match_req_dispatch_if.sv
// Group input, match_resp_sync announce and per-channel request bus.
// slave is the dispatcher side, master the group source / channel sink side.
interface match_req_dispatch_if;
   import match_req_dispatch_pkg::*;

   logic                                 in_valid;
   logic                                 in_ready;
   lane_mask_t                           in_strb;
   addr_t                                in_head_addr;
   logic                                 sync_group_valid;
   lane_mask_t                           sync_group_strb;
   ch_mask_t                             req_valid;
   ch_mask_t                             req_ready;
   logic [NUM_MATCH_REQ_CH*TAG_BITS-1:0]  req_tag;
   logic [NUM_MATCH_REQ_CH*ADDR_BITS-1:0] req_addr;
   logic                                 resp_group_done;

   modport slave (
      input  in_valid, in_strb, in_head_addr, req_ready, resp_group_done,
      output in_ready, sync_group_valid, sync_group_strb, req_valid, req_tag, req_addr
   );

   modport master (
      output in_valid, in_strb, in_head_addr, req_ready, resp_group_done,
      input  in_ready, sync_group_valid, sync_group_strb, req_valid, req_tag, req_addr
   );

endinterface

// File: rtl/match_req_dispatch_lane_pick.sv
// Combinational lane allocator: hands the lowest pending lanes to free
// channels in ascending channel order and returns the remaining mask.
module lane_pick_lowest
   import match_req_dispatch_pkg::*;
(
   input  lane_mask_t                        pending,
   input  ch_mask_t                          free,
   output ch_mask_t                          assign_vld_c,
   output tag_t [NUM_MATCH_REQ_CH-1:0]       ch_lane_c,
   output lane_mask_t                        pending_next_c
);

   lane_mask_t rem;
   tag_t       lane;

   always_comb begin
      rem          = pending;
      lane         = '0;
      assign_vld_c = '0;
      ch_lane_c    = '0;
      for (int c = 0; c < int'(NUM_MATCH_REQ_CH); c++) begin
         if (free[c] && (rem != '0)) begin
            lane            = lowest_lane(rem);
            ch_lane_c[c]    = lane;
            assign_vld_c[c] = 1'b1;
            rem[lane]       = 1'b0;
         end
      end
      pending_next_c = rem;
   end

endmodule

// File: rtl/match_req_dispatch.sv
// Spreads one lazy-evaluation group of match requests over the match_pe
// request channels, announcing the group to match_resp_sync first.
module match_req_dispatch
   import match_req_dispatch_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   match_req_dispatch_if.slave  bus
);

   state_t                                state_q, state_d;
   lane_mask_t                            pending_q, pending_d;
   lane_mask_t                            sync_strb_q, sync_strb_d;
   addr_t                                 head_q, head_d;
   logic                                  sync_valid_q, sync_valid_d;
   logic                                  in_ready_q, in_ready_d;
   logic                                  done_q, done_d;
   ch_mask_t                              req_valid_q, req_valid_d;
   req_payload_t [NUM_MATCH_REQ_CH-1:0]   req_pld_q, req_pld_d;

   ch_mask_t                              free_c;
   ch_mask_t                              hold_c;
   ch_mask_t                              assign_vld_c;
   tag_t [NUM_MATCH_REQ_CH-1:0]           ch_lane_c;
   lane_mask_t                            pending_next_c;

   assign free_c = ~req_valid_q | bus.req_ready;
   assign hold_c = req_valid_q & ~bus.req_ready;

   lane_pick_lowest u_pick (
      .pending        (pending_q),
      .free           (free_c),
      .assign_vld_c   (assign_vld_c),
      .ch_lane_c      (ch_lane_c),
      .pending_next_c (pending_next_c)
   );

   // Next-state and channel register update.
   always_comb begin
      state_d      = state_q;
      pending_d    = pending_q;
      sync_strb_d  = sync_strb_q;
      head_d       = head_q;
      sync_valid_d = 1'b0;
      in_ready_d   = in_ready_q;
      done_d       = done_q;
      req_valid_d  = req_valid_q;
      req_pld_d    = req_pld_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               pending_d    = bus.in_strb;
               sync_strb_d  = bus.in_strb;
               head_d       = bus.in_head_addr;
               sync_valid_d = 1'b1;
               in_ready_d   = 1'b0;
               done_d       = 1'b0;
               state_d      = ST_ANNOUNCE;
            end
         end
         ST_ANNOUNCE, ST_ISSUE: begin
            // A response group may finish before we reach WAIT (empty strobe).
            if (bus.resp_group_done) done_d = 1'b1;
            for (int c = 0; c < int'(NUM_MATCH_REQ_CH); c++) begin
               if (free_c[c]) begin
                  req_valid_d[c] = assign_vld_c[c];
                  if (assign_vld_c[c]) begin
                     req_pld_d[c].tag  = ch_lane_c[c];
                     req_pld_d[c].addr = head_q + ADDR_BITS'(ch_lane_c[c]);
                  end
               end
            end
            pending_d = pending_next_c;
            if (state_q == ST_ANNOUNCE) begin
               state_d = ST_ISSUE;
            end else if ((pending_q == '0) && (hold_c == '0)) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.resp_group_done || done_q) begin
               done_d     = 1'b0;
               in_ready_d = 1'b1;
               state_d    = ST_IDLE;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            in_ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         pending_q    <= '0;
         sync_strb_q  <= '0;
         head_q       <= '0;
         sync_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
         done_q       <= 1'b0;
         req_valid_q  <= '0;
         req_pld_q    <= '0;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         sync_strb_q  <= sync_strb_d;
         head_q       <= head_d;
         sync_valid_q <= sync_valid_d;
         in_ready_q   <= in_ready_d;
         done_q       <= done_d;
         req_valid_q  <= req_valid_d;
         req_pld_q    <= req_pld_d;
      end
   end

   assign bus.in_ready         = in_ready_q;
   assign bus.sync_group_valid = sync_valid_q;
   assign bus.sync_group_strb  = sync_strb_q;
   assign bus.req_valid        = req_valid_q;

   for (genvar g = 0; g < int'(NUM_MATCH_REQ_CH); g++) begin : g_flat
      assign bus.req_tag[g*TAG_BITS +: TAG_BITS]    = req_pld_q[g].tag;
      assign bus.req_addr[g*ADDR_BITS +: ADDR_BITS] = req_pld_q[g].addr;
   end

endmodule

// File: tb/tb_match_req_dispatch.sv
// Directed bench for match_req_dispatch with L=4 lanes on C=2 channels.
module tb_match_req_dispatch;
   import match_req_dispatch_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   match_req_dispatch_if bus();

   match_req_dispatch dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", name, obs, exp);
      end
   endtask

   // Channel c carries a valid request for lane with address a.
   task automatic chk_ch(input string name, input int c, input int lane, input addr_t a);
      chk({name, ".valid"}, 64'(bus.req_valid[c]), 64'd1);
      chk({name, ".tag"},   64'(bus.req_tag[c*TAG_BITS +: TAG_BITS]), 64'(lane));
      chk({name, ".addr"},  64'(bus.req_addr[c*ADDR_BITS +: ADDR_BITS]), 64'(a));
   endtask

   task automatic accept(input lane_mask_t strb, input addr_t head);
      bus.in_strb      = strb;
      bus.in_head_addr = head;
      bus.in_valid     = 1'b1;
      tick();
      bus.in_valid     = 1'b0;
   endtask

   task automatic finish_group(input string name);
      bus.resp_group_done = 1'b1;
      tick();
      bus.resp_group_done = 1'b0;
      chk({name, ".in_ready_back"}, 64'(bus.in_ready), 64'd1);
   endtask

   initial begin
      rst                 = 1'b1;
      bus.in_valid        = 1'b0;
      bus.in_strb         = '0;
      bus.in_head_addr    = '0;
      bus.req_ready       = '0;
      bus.resp_group_done = 1'b0;
      tick();
      tick();
      chk("rst.in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst.sync_v",   64'(bus.sync_group_valid), 64'd0);
      chk("rst.sync_strb",64'(bus.sync_group_strb), 64'd0);
      chk("rst.req_valid",64'(bus.req_valid), 64'd0);
      chk("rst.req_tag",  64'(bus.req_tag), 64'd0);
      chk("rst.req_addr", 64'(bus.req_addr), 64'd0);
      rst = 1'b0;
      tick();

      // Full group, both channels always ready
      bus.req_ready = 2'b11;
      accept(4'b1111, 32'h100);
      chk("full.sync_v",    64'(bus.sync_group_valid), 64'd1);
      chk("full.sync_strb", 64'(bus.sync_group_strb), 64'hF);
      chk("full.t1_valid",  64'(bus.req_valid), 64'd0);
      chk("full.in_ready",  64'(bus.in_ready), 64'd0);
      tick();
      chk("full.t2_sync_v", 64'(bus.sync_group_valid), 64'd0);
      chk_ch("full.t2c0", 0, 0, 32'h100);
      chk_ch("full.t2c1", 1, 1, 32'h101);
      tick();
      chk_ch("full.t3c0", 0, 2, 32'h102);
      chk_ch("full.t3c1", 1, 3, 32'h103);
      tick();
      chk("full.wait_valid", 64'(bus.req_valid), 64'd0);
      chk("full.wait_ready", 64'(bus.in_ready), 64'd0);
      finish_group("full");

      // Sparse strobe
      accept(4'b1010, 32'h200);
      chk("sparse.sync_strb", 64'(bus.sync_group_strb), 64'hA);
      tick();
      chk_ch("sparse.t2c0", 0, 1, 32'h201);
      chk_ch("sparse.t2c1", 1, 3, 32'h203);
      tick();
      chk("sparse.t3_valid", 64'(bus.req_valid), 64'd0);
      tick();
      chk("sparse.wait_hold", 64'(bus.in_ready), 64'd0);
      finish_group("sparse");

      // Backpressure on ch0 for three cycles
      bus.req_ready = 2'b10;
      accept(4'b1111, 32'h300);
      tick();
      chk_ch("bp.t2c0", 0, 0, 32'h300);
      chk_ch("bp.t2c1", 1, 1, 32'h301);
      tick();
      chk_ch("bp.t3c0", 0, 0, 32'h300);
      chk_ch("bp.t3c1", 1, 2, 32'h302);
      tick();
      chk_ch("bp.t4c0", 0, 0, 32'h300);
      chk_ch("bp.t4c1", 1, 3, 32'h303);
      tick();
      bus.req_ready = 2'b11;
      chk_ch("bp.t5c0", 0, 0, 32'h300);
      chk("bp.t5_valid", 64'(bus.req_valid), 64'b01);
      tick();
      chk("bp.t6_valid", 64'(bus.req_valid), 64'd0);
      chk("bp.t6_ready", 64'(bus.in_ready), 64'd0);
      finish_group("bp");

      // Empty strobe, completion arrives in ISSUE
      accept(4'b0000, 32'h400);
      chk("empty.sync_v",    64'(bus.sync_group_valid), 64'd1);
      chk("empty.sync_strb", 64'(bus.sync_group_strb), 64'd0);
      chk("empty.t1_valid",  64'(bus.req_valid), 64'd0);
      tick();
      chk("empty.t2_valid",  64'(bus.req_valid), 64'd0);
      bus.resp_group_done = 1'b1;
      tick();
      bus.resp_group_done = 1'b0;
      chk("empty.t3_ready",  64'(bus.in_ready), 64'd0);
      tick();
      chk("empty.t4_ready",  64'(bus.in_ready), 64'd1);

      // Address wrap
      accept(4'b1111, 32'hFFFF_FFFE);
      tick();
      chk_ch("wrap.t2c0", 0, 0, 32'hFFFF_FFFE);
      chk_ch("wrap.t2c1", 1, 1, 32'hFFFF_FFFF);
      tick();
      chk_ch("wrap.t3c0", 0, 2, 32'h0000_0000);
      chk_ch("wrap.t3c1", 1, 3, 32'h0000_0001);
      tick();
      finish_group("wrap");

      // Reset during ISSUE with two lanes pending
      bus.req_ready = 2'b00;
      accept(4'b1111, 32'h500);
      tick();
      chk_ch("rstmid.t2c0", 0, 0, 32'h500);
      chk_ch("rstmid.t2c1", 1, 1, 32'h501);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstmid.valid",    64'(bus.req_valid), 64'd0);
      chk("rstmid.sync_v",   64'(bus.sync_group_valid), 64'd0);
      chk("rstmid.in_ready", 64'(bus.in_ready), 64'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rstmid.quiet_valid", 64'(bus.req_valid), 64'd0);
         chk("rstmid.quiet_sync",  64'(bus.sync_group_valid), 64'd0);
         chk("rstmid.quiet_ready", 64'(bus.in_ready), 64'd1);
      end

      // Clean group after reset
      bus.req_ready = 2'b11;
      accept(4'b0011, 32'h600);
      chk("post.sync_strb", 64'(bus.sync_group_strb), 64'h3);
      tick();
      chk_ch("post.t2c0", 0, 0, 32'h600);
      chk_ch("post.t2c1", 1, 1, 32'h601);
      tick();
      chk("post.t3_valid", 64'(bus.req_valid), 64'd0);
      finish_group("post");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
